// File: rtl/sddr_port_arbiter.sv
// Round-robin arbiter sharing the sddr controller data command/response port among NUM_PORTS requesters.
// Define SDDR_ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module sddr_port_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_BITS   = 27,
  parameter int unsigned DATA_BITS   = 128,
  parameter int unsigned RSP_TIMEOUT = 1024
) (
  input  logic                           cpu_clock_i,
  input  logic                           cpu_reset_n_i,
  input  logic [NUM_PORTS-1:0]           req_valid_i,
  input  logic [NUM_PORTS-1:0]           req_write_i,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] req_address_i,
  input  logic [NUM_PORTS*DATA_BITS-1:0] req_data_i,
  output logic [NUM_PORTS-1:0]           req_ack_o,
  output logic [NUM_PORTS-1:0]           rsp_ready_o,
  output logic                           rsp_error_o,
  output logic [DATA_BITS-1:0]           rsp_data_o,
  output logic                           mem_cmd_valid_o,
  output logic [ADDR_BITS-1:0]           mem_cmd_address_o,
  output logic                           mem_cmd_write_o,
  output logic [DATA_BITS-1:0]           mem_cmd_data_o,
  input  logic                           mem_cmd_ack_i,
  input  logic                           mem_rsp_ready_i,
  input  logic [DATA_BITS-1:0]           mem_rsp_data_i,
  output logic                           busy_o
);

  localparam int unsigned PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned TW     = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam bit          TMO_EN = (RSP_TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [PW-1:0]        owner_q;
  logic [PW-1:0]        winner;
  logic                 win_found;
  logic [NUM_PORTS-1:0] win_onehot;
  logic [NUM_PORTS-1:0] owner_onehot;
  logic                 rsp_prev_q;
  logic                 rsp_edge;
  logic [TW-1:0]        timeout_q;
  logic                 accept;
  logic                 cmd_done;
  logic                 rsp_complete;
  logic                 rsp_expire;

`ifndef SDDR_ARB_FIXED_PRIORITY_EN
  logic [PW-1:0]        last_grant_q;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int unsigned step);
    int unsigned sum;
    sum = 32'(base) + step;
    return PW'(sum % NUM_PORTS);
  endfunction
`endif

  // Winner selection
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
`ifdef SDDR_ARB_FIXED_PRIORITY_EN
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && req_valid_i[i]) begin
        winner    = PW'(i);
        win_found = 1'b1;
      end
    end
`else
    // scan starts one past the last grant so every port gets a turn
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      if (!win_found && req_valid_i[rr_index(last_grant_q, k)]) begin
        winner    = rr_index(last_grant_q, k);
        win_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    win_onehot   = '0;
    owner_onehot = '0;
    if (win_found) win_onehot[winner] = 1'b1;
    owner_onehot[owner_q] = 1'b1;
  end

  assign req_ack_o = (state_q == IDLE) ? win_onehot : '0;
  assign accept    = (state_q == IDLE) && win_found;
  assign cmd_done  = (state_q == ISSUE) && mem_cmd_ack_i;
  assign rsp_edge  = mem_rsp_ready_i && !rsp_prev_q;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    rsp_complete = 1'b0;
    rsp_expire   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_cmd_ack_i) state_d = mem_cmd_write_o ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        // a response edge on the expiry cycle still counts as a good completion
        if (rsp_edge) begin
          rsp_complete = 1'b1;
          state_d      = IDLE;
        end else if (TMO_EN && (timeout_q == TW'(1))) begin
          rsp_expire = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      state_q           <= IDLE;
      owner_q           <= '0;
      rsp_prev_q        <= 1'b0;
      timeout_q         <= '0;
      busy_o            <= 1'b0;
      mem_cmd_valid_o   <= 1'b0;
      mem_cmd_address_o <= '0;
      mem_cmd_write_o   <= 1'b0;
      mem_cmd_data_o    <= '0;
      rsp_ready_o       <= '0;
      rsp_error_o       <= 1'b0;
      rsp_data_o        <= '0;
    end else begin
      state_q     <= state_d;
      busy_o      <= (state_d != IDLE);
      rsp_prev_q  <= mem_rsp_ready_i;
      rsp_ready_o <= '0;
      rsp_error_o <= 1'b0;

      if (accept) begin
        mem_cmd_valid_o   <= 1'b1;
        mem_cmd_address_o <= req_address_i[32'(winner)*ADDR_BITS +: ADDR_BITS];
        mem_cmd_write_o   <= req_write_i[winner];
        mem_cmd_data_o    <= req_data_i[32'(winner)*DATA_BITS +: DATA_BITS];
        owner_q           <= winner;
      end

      if (cmd_done) begin
        mem_cmd_valid_o <= 1'b0;
        if (!mem_cmd_write_o && TMO_EN) timeout_q <= TW'(RSP_TIMEOUT);
      end

      if (state_q == WAIT_RSP && timeout_q != '0) timeout_q <= timeout_q - TW'(1);

      if (rsp_complete) begin
        rsp_ready_o <= owner_onehot;
        rsp_data_o  <= mem_rsp_data_i;
        timeout_q   <= '0;
      end else if (rsp_expire) begin
        rsp_ready_o <= owner_onehot;
        rsp_error_o <= 1'b1;
        rsp_data_o  <= '0;
      end
    end
  end

`ifndef SDDR_ARB_FIXED_PRIORITY_EN
  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      last_grant_q <= PW'(NUM_PORTS - 1);
    end else if (accept) begin
      last_grant_q <= winner;
    end
  end
`endif

endmodule

// File: tb/tb_sddr_port_arbiter.sv
// Bench for sddr_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_sddr_port_arbiter;

  localparam int NP  = 4;
  localparam int AB  = 27;
  localparam int DB  = 128;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    req_valid = '0;
  logic [NP-1:0]    req_write = '0;
  logic [NP*AB-1:0] req_address = '0;
  logic [NP*DB-1:0] req_data = '0;
  logic [NP-1:0]    req_ack;
  logic [NP-1:0]    rsp_ready;
  logic             rsp_error;
  logic [DB-1:0]    rsp_data;
  logic             mem_cmd_valid;
  logic [AB-1:0]    mem_cmd_address;
  logic             mem_cmd_write;
  logic [DB-1:0]    mem_cmd_data;
  logic             mem_cmd_ack = 1'b0;
  logic             mem_rsp_ready = 1'b0;
  logic [DB-1:0]    mem_rsp_data = '0;
  logic             busy;

  always #5 clk = ~clk;

  sddr_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .RSP_TIMEOUT(TMO)
  ) dut (
    .cpu_clock_i(clk), .cpu_reset_n_i(rst_n),
    .req_valid_i(req_valid), .req_write_i(req_write),
    .req_address_i(req_address), .req_data_i(req_data),
    .req_ack_o(req_ack), .rsp_ready_o(rsp_ready), .rsp_error_o(rsp_error), .rsp_data_o(rsp_data),
    .mem_cmd_valid_o(mem_cmd_valid), .mem_cmd_address_o(mem_cmd_address),
    .mem_cmd_write_o(mem_cmd_write), .mem_cmd_data_o(mem_cmd_data),
    .mem_cmd_ack_i(mem_cmd_ack), .mem_rsp_ready_i(mem_rsp_ready), .mem_rsp_data_i(mem_rsp_data),
    .busy_o(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_cmd_out;   // command presented, not yet taken by controller
  bit            m_rsp_wait;  // read taken, response outstanding
  int            m_owner;
  int            m_last;
  int            m_wait;      // cycles elapsed since the controller took the read
  bit            m_prev;
  logic          e_cmd_valid, e_write, e_err, e_busy;
  logic [AB-1:0] e_addr;
  logic [DB-1:0] e_data, e_rdata;
  logic [NP-1:0] e_ready;

  function automatic int pick(input logic [NP-1:0] v, input int last);
`ifdef SDDR_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NP; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NP; k++) if (v[(last + k) % NP]) return (last + k) % NP;
`endif
    return -1;
  endfunction

  task automatic m_reset();
    m_cmd_out = 0; m_rsp_wait = 0; m_owner = 0; m_last = NP - 1; m_wait = 0; m_prev = 0;
    e_cmd_valid = 0; e_write = 0; e_err = 0; e_busy = 0;
    e_addr = '0; e_data = '0; e_rdata = '0; e_ready = '0;
  endtask

  task automatic m_step();
    bit rise;
    int w;
    rise    = mem_rsp_ready && !m_prev;
    e_ready = '0;
    e_err   = 0;
    if (!m_cmd_out && !m_rsp_wait) begin
      w = pick(req_valid, m_last);
      if (w >= 0) begin
        e_addr = req_address[w*AB +: AB];
        e_write = req_write[w];
        e_data = req_data[w*DB +: DB];
        e_cmd_valid = 1; m_owner = w; m_last = w; m_cmd_out = 1;
      end
    end else if (m_cmd_out) begin
      if (mem_cmd_ack) begin
        e_cmd_valid = 0; m_cmd_out = 0;
        if (!e_write) begin m_rsp_wait = 1; m_wait = 0; end
      end
    end else begin
      m_wait++;
      if (rise) begin
        e_ready[m_owner] = 1; e_rdata = mem_rsp_data; m_rsp_wait = 0;
      end else if (TMO != 0 && m_wait == TMO) begin
        e_ready[m_owner] = 1; e_err = 1; e_rdata = '0; m_rsp_wait = 0;
      end
    end
    m_prev = mem_rsp_ready;
    e_busy = m_cmd_out || m_rsp_wait;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare + grant recorder ----------------
  bit rec_en = 0;
  int grants[$];

  initial forever begin : cmp_loop
    logic [NP-1:0] ea;
    int w;
    @(negedge clk);
    ea = '0;
    if (!m_cmd_out && !m_rsp_wait) begin
      w = pick(req_valid, m_last);
      if (w >= 0) ea[w] = 1'b1;
    end
    chk("req_ack", DB'(req_ack), DB'(ea));
    chk("cmd_valid", DB'(mem_cmd_valid), DB'(e_cmd_valid));
    chk("cmd_addr", DB'(mem_cmd_address), DB'(e_addr));
    chk("cmd_write", DB'(mem_cmd_write), DB'(e_write));
    chk("cmd_data", mem_cmd_data, e_data);
    chk("rsp_ready", DB'(rsp_ready), DB'(e_ready));
    chk("rsp_error", DB'(rsp_error), DB'(e_err));
    chk("rsp_data", rsp_data, e_rdata);
    chk("busy", DB'(busy), DB'(e_busy));
    if (rec_en && (req_valid & req_ack) != '0)
      for (int p = 0; p < NP; p++) if (req_ack[p]) grants.push_back(p);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req_valid = '0; mem_cmd_ack = 0; mem_rsp_ready = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic wait_rsp(input int max, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_ready != '0) begin cyc = i; return; end
    end
  endtask

  logic [DB-1:0] pat_a5;
  logic [DB-1:0] pat_b;
  logic [DB-1:0] pat_c;
  int            exp_order[6];
  int            cyc;
  bit            quiet;

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_b  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    pat_c  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    step(); step();
    rst_n = 1;
    step();

    // 1: single read from port 2
    req_write = '0;
    req_address[2*AB +: AB] = 27'h0123456;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("t1_cmd_valid", DB'(mem_cmd_valid), DB'(1'b1));
    chk("t1_cmd_addr", DB'(mem_cmd_address), DB'(27'h0123456));
    chk("t1_cmd_write", DB'(mem_cmd_write), DB'(1'b0));
    step(); step();
    mem_cmd_ack = 1;
    step();
    mem_cmd_ack = 0;
    repeat (9) step();
    mem_rsp_data = pat_a5;
    mem_rsp_ready = 1;
    wait_rsp(30, cyc);
    chk("t1_rsp_seen", DB'(cyc != 0), DB'(1'b1));
    chk("t1_rsp_ready", DB'(rsp_ready), DB'(4'b0100));
    chk("t1_rsp_data", rsp_data, pat_a5);
    chk("t1_rsp_error", DB'(rsp_error), DB'(1'b0));
    step();
    mem_rsp_ready = 0;
    step();

    // 2: all ports writing, controller always ready
    do_reset();
    for (int p = 0; p < NP; p++) req_address[p*AB +: AB] = AB'($urandom);
    req_write = '1;
    req_valid = '1;
    mem_cmd_ack = 1;
    rec_en = 1;
    repeat (14) step();
    rec_en = 0;
    req_valid = '0;
    mem_cmd_ack = 0;
`ifdef SDDR_ARB_FIXED_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0, 1};
`endif
    chk("t2_grant_count", DB'(grants.size() >= 6), DB'(1'b1));
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk($sformatf("t2_grant%0d", i), DB'(grants[i]), DB'(exp_order[i]));

    // 6: response edge on the same cycle the timeout expires
    do_reset();
    req_write = '0;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    mem_cmd_ack = 1;
    step();
    mem_cmd_ack = 0;
    repeat (TMO - 1) step();
    mem_rsp_data = pat_b;
    mem_rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rsp_ready", DB'(rsp_ready), DB'(4'b1000));
    chk("t6_rsp_error", DB'(rsp_error), DB'(1'b0));
    chk("t6_rsp_data", rsp_data, pat_b);
    step();
    mem_rsp_ready = 0;
    step();

    // 3: lost response times out after TMO cycles
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    mem_cmd_ack = 1;
    step();
    mem_cmd_ack = 0;
    wait_rsp(40, cyc);
    chk("t3_timeout_cycles", DB'(cyc), DB'(TMO));
    chk("t3_rsp_ready", DB'(rsp_ready), DB'(4'b0010));
    chk("t3_rsp_error", DB'(rsp_error), DB'(1'b1));
    chk("t3_rsp_data", rsp_data, '0);
    chk("t3_busy", DB'(busy), DB'(1'b0));
    step();

    // 4: stale high response level is ignored until it toggles
    mem_rsp_ready = 1;
    mem_rsp_data = pat_c;
    step(); step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    mem_cmd_ack = 1;
    step();
    mem_cmd_ack = 0;
    repeat (5) step();
    chk("t4_no_rsp", DB'(rsp_ready), DB'(4'b0000));
    chk("t4_busy", DB'(busy), DB'(1'b1));
    mem_rsp_ready = 0;
    step();
    mem_rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_rsp_ready", DB'(rsp_ready), DB'(4'b0001));
    chk("t4_rsp_data", rsp_data, pat_c);
    step();
    mem_rsp_ready = 0;
    step();

    // 5: reset while a command is being presented
    req_valid = 4'b1000;
    step();
    chk("t5_cmd_valid_pre", DB'(mem_cmd_valid), DB'(1'b1));
    req_valid = '0;
    rst_n = 0;
    #1;
    chk("t5_cmd_valid_rst", DB'(mem_cmd_valid), DB'(1'b0));
    chk("t5_busy_rst", DB'(busy), DB'(1'b0));
    chk("t5_addr_rst", DB'(mem_cmd_address), DB'(0));
    chk("t5_ack_rst", DB'(req_ack), DB'(0));
    step();
    req_valid = 4'b1001;
    rst_n = 1;
    #1;
    chk("t5_first_grant", DB'(req_ack), DB'(4'b0001));
    step();
    req_valid = '0;
    mem_cmd_ack = 1;
    step();
    mem_cmd_ack = 0;
    repeat (TMO + 4) step();

    // randomized traffic
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) quiet = ($urandom_range(0, 3) == 0);
      if (c % 700 == 350) rst_n = 0;
      else rst_n = 1;
      req_valid = ($urandom_range(0, 2) == 0) ? NP'($urandom) : '0;
      req_write = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        req_address[p*AB +: AB] = AB'($urandom);
        req_data[p*DB +: DB] = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_cmd_ack = ($urandom_range(0, 1) == 1);
      mem_rsp_ready = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
      mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    rst_n = 1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sddr_port_arbiter.md
Name: sddr_port_arbiter

Overview:
- Shares the single data command/response interface of the simple DDR controller between NUM_PORTS requesters in the CPU clock domain.
- Arbitrates round-robin and forwards one command at a time.
- Holds grants until a read's response returns, then routes the response back to the owning port.
- Guards against a lost response with a timeout that completes the read with an error flag.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
ADDR_BITS, 27, byte address width (bank+row+col+byte-select of the controller)
DATA_BITS, 128, full burst payload width (burst length x DQ width)
RSP_TIMEOUT, 1024, cycles to wait for a read response after command accept; 0 disables timeout

Ports:
cpu_clock_i  in  1  clock (CPU domain)
cpu_reset_n_i  in  1  asynchronous active-low reset
req_valid_i  in  NUM_PORTS  per-port request valid
req_write_i  in  NUM_PORTS  per-port 1=write, 0=read
req_address_i  in  NUM_PORTS*ADDR_BITS  per-port address, port p at [p*ADDR_BITS +: ADDR_BITS]
req_data_i  in  NUM_PORTS*DATA_BITS  per-port write data, same packing
req_ack_o  out  NUM_PORTS  one-hot accept; transfer when valid&&ack
rsp_ready_o  out  NUM_PORTS  one-hot, one-cycle read-completion pulse
rsp_error_o  out  1  qualifies rsp_ready_o; 1=timeout, data invalid
rsp_data_o  out  DATA_BITS  read data, valid with rsp_ready_o, held until next completion
mem_cmd_valid_o  out  1  to controller data_cmd_valid
mem_cmd_address_o  out  ADDR_BITS  to controller
mem_cmd_write_o  out  1  to controller
mem_cmd_data_o  out  DATA_BITS  to controller
mem_cmd_ack_i  in  1  from controller data_cmd_ack (level ready)
mem_rsp_ready_i  in  1  from controller data_rsp_ready (level, may stay high)
mem_rsp_data_i  in  DATA_BITS  from controller
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, grant owner 0, last_grant=NUM_PORTS-1 (port 0 wins first), rsp_prev=0, timeout counter 0. Reset mid-operation abandons any command/response; no pulses are emitted afterwards for it.
- States IDLE, ISSUE, WAIT_RSP.
- IDLE: winner = first set req_valid_i scanning from last_grant+1 modulo NUM_PORTS. req_ack_o is combinational: one-hot winner while in IDLE, else 0.
- On valid&&ack: latch address, write and data into the mem_cmd_* registers; set mem_cmd_valid_o=1 and owner=winner; last_grant<=winner; go to ISSUE. Acceptance takes 1 cycle, so there is at most one accept per two cycles.
- ISSUE: mem_cmd_* stay stable. When mem_cmd_ack_i=1, mem_cmd_valid_o<=0 the same edge.
  - Write: the controller returns no completion; go to IDLE.
  - Read: load timeout=RSP_TIMEOUT and go to WAIT_RSP.
- WAIT_RSP: completion happens only on a rising edge (mem_rsp_ready_i=1 && rsp_prev=0). A level already high on entry is stale and ignored. rsp_prev samples mem_rsp_ready_i every cycle.
  - On completion: rsp_data_o<=mem_rsp_data_i, rsp_ready_o[owner] pulses 1 cycle, rsp_error_o=0, go to IDLE.
  - Timeout decrements each cycle. If it reaches 0 without an edge: rsp_ready_o[owner]=1 and rsp_error_o=1 for 1 cycle, rsp_data_o<=0, go to IDLE.
  - Edge and expiry in the same cycle: the response wins and error=0.
  - RSP_TIMEOUT=0: the counter is never loaded and the arbiter waits indefinitely.
- Requesters may drop req_valid_i without an ack; this has no side effect. Only one transaction is in flight, so responses are always in order.
- busy_o is registered, equivalent to state != IDLE.

Optional Feature:
- SDDR_ARB_FIXED_PRIORITY_EN defined: winner = lowest-index valid port; last_grant is not updated or used.
- Undefined: round-robin as above.

Test Plan:
1. Only port 2 reads addr 0x0123456; mem_cmd_ack_i high 3 cycles after valid; rsp edge 10 cycles later with data 0xA5..A5 -> mem_cmd_address_o=0x0123456, write=0; rsp_ready_o=4'b0100 for 1 cycle, rsp_data_o=0xA5..A5, rsp_error_o=0.
2. All 4 ports hold write requests; mem_cmd_ack_i tied 1 -> grant order 0,1,2,3,0,1; each req_ack_o is a single-cycle one-hot. With SDDR_ARB_FIXED_PRIORITY_EN -> 0,0,0 until port 0 drops valid.
3. RSP_TIMEOUT=16; read accepted, no response -> 16 cycles after mem_cmd_ack_i, rsp_ready_o[owner]=1 with rsp_error_o=1, rsp_data_o=0; state returns to IDLE.
4. mem_rsp_ready_i held high from before a read is issued -> no completion until it goes low then high; completion then occurs one cycle after the rising edge.
5. Reset asserted while in ISSUE with mem_cmd_valid_o=1 -> all outputs 0 immediately; after release with ports 0 and 3 valid, port 0 is granted first.
6. Response rising edge coincides with the timeout reaching 0 -> rsp_ready_o pulse with rsp_error_o=0 and the captured data.
